ecc_chk_arbiter: RTL and testbench
==================================

Name: ecc_chk_arbiter

Overview:
- Round-robin scheduler that shares one ecc_err_type_ctrl classifier among NUM_REQ requesters (e.g. per-subchannel read paths).
- Accepts one data/syndrome beat at a time with a valid/ready handshake, sequences it through the classifier, and returns the classification plus corrected data tagged with the requester ID.
- Quarantines any requester that produced an uncorrectable error until software clears it, and keeps saturating CE/UE statistics.

Parameters:
NUM_REQ, 4, number of requesters (>=2); ID_W = $clog2(NUM_REQ) is a localparam
DATA_WIDTH, 128, data beat width; must match the classifier
ECC_WIDTH, 16, syndrome width; must match the classifier
CE_THRESH, 8'd16, correctable-error count at which ce_alert fires (optional feature only)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant/accept
req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_syndrome  in  NUM_REQ*ECC_WIDTH  packed syndromes, same packing
chk_valid  out  1  classifier ecc_valid
chk_enable  out  1  classifier enable
chk_data  out  DATA_WIDTH  classifier data_in
chk_syndrome  out  ECC_WIDTH  classifier ecc_syndrome
chk_error_detected  in  1  from classifier
chk_is_correctable  in  1  from classifier
chk_is_uncorrectable  in  1  from classifier
chk_data_corrected  in  DATA_WIDTH  from classifier
rsp_valid  out  1  one-cycle response pulse
rsp_id  out  ID_W  requester the response belongs to
rsp_data  out  DATA_WIDTH  corrected data; raw data on UE
rsp_ce  out  1  correctable error flag
rsp_ue  out  1  uncorrectable error flag
blocked  out  NUM_REQ  quarantine mask
ue_clear  in  NUM_REQ  per-requester unblock pulse
ue_irq  out  1  level; equals OR of blocked
ce_count  out  8  saturating correctable-error count
ue_count  out  8  saturating uncorrectable-error count
ce_alert  out  1  CE threshold alert

Behaviour:
- Reset values (asynchronous, active-low): all outputs 0, FSM in IDLE, rr_ptr=0. Reset mid-transaction drops the in-flight beat and issues no response.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, arbitration:
  - Eligible requesters are req_valid & ~blocked.
  - Grant goes to the first eligible index searching upward from rr_ptr, wrapping at NUM_REQ.
  - req_ready is asserted combinationally, only in IDLE, one-hot to the granted requester.
  - A handshake (valid & ready) latches data, syndrome and ID, sets rr_ptr = granted ID + 1 (wrapping NUM_REQ-1 -> 0), and moves to ISSUE.
  - With no eligible requester, stay in IDLE.
- ISSUE:
  - chk_valid=1 and chk_enable=1 for exactly one cycle.
  - chk_data and chk_syndrome are driven from the latched registers.
  - Next state is WAIT.
- WAIT:
  - chk_enable=1 and chk_valid=0. chk_enable stays high because the classifier's statistics logic samples enable while error_detected is high.
  - This cycle samples chk_* outputs, which are registered one cycle after chk_valid.
  - Next state is IDLE.
- Response:
  - Registered on WAIT exit: rsp_valid=1 for one cycle, in the cycle the FSM re-enters IDLE.
  - rsp_id = latched ID.
  - rsp_ce = chk_error_detected & chk_is_correctable.
  - rsp_ue = chk_error_detected & chk_is_uncorrectable.
  - rsp_data = chk_data_corrected.
  - rsp_* other than rsp_valid hold until the next response.
- Latency and throughput: a handshake at cycle T gives rsp_valid at T+3. A new handshake can occur in that same cycle, so one beat per 3 cycles.
- No backpressure on responses.
- UE quarantine:
  - A response with rsp_ue=1 sets blocked[rsp_id] in the same cycle that rsp_valid is asserted.
  - ue_clear[i] clears blocked[i] the next cycle.
  - A simultaneous set and clear on the same bit: set wins.
  - ue_clear on an unblocked bit has no effect.
  - A blocked requester is never granted; its req_valid may stay high indefinitely.
- Counters:
  - ce_count increments on each response with rsp_ce; ue_count increments on each response with rsp_ue.
  - Both saturate at 8'hFF and are cleared only by reset.
- chk_enable and chk_valid are 0 in IDLE.

Optional Feature:
ECC_ARB_CE_THRESH_EN
- Defined: ce_alert is set the cycle ce_count becomes >= CE_THRESH. It is sticky until reset, and stays set through counter saturation.
- Not defined: ce_alert is tied 0 and no threshold compare logic is built.
- In both cases the port remains.

Test Plan:
- Single beat: req_valid[2]=1 with syndrome 16'h0004 at T; classifier returns CE. Expect req_ready=4'b0100 at T; chk_valid at T+1; rsp_valid, rsp_id=2, rsp_ce=1, rsp_ue=0 at T+3; ce_count=1.
- Round-robin fairness: all four req_valid held high for 12 beats. Expect grant order 0,1,2,3,0,1,2,3,... with each handshake 3 cycles apart.
- UE quarantine:
  - Requester 1 returns UE (syndrome 16'h0003). Expect rsp_ue=1, blocked=4'b0010, ue_irq=1, and requester 1 skipped in subsequent arbitration.
  - ue_clear[1] pulse. Expect blocked=0 the next cycle and requester 1 granted again.
  - Same-cycle UE set and ue_clear[1]: blocked[1] stays 1.
- Saturation and alert: 300 CE responses. Expect ce_count=8'hFF thereafter. With ECC_ARB_CE_THRESH_EN, ce_alert rises in the response cycle where the count reaches 16 and stays high.
- Reset mid-operation: assert rst_n=0 while in WAIT. Expect no rsp_valid, all outputs 0, blocked=0, and the first grant after release going to requester 0.

Source files
------------

// File: rtl/ecc_chk_arbiter.sv
// Round-robin front end that shares one ECC error classifier among NUM_REQ requesters.
// Optional: `define ECC_ARB_CE_THRESH_EN builds the sticky CE threshold alert on ce_alert.
module ecc_chk_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter int          DATA_WIDTH = 128,
    parameter int          ECC_WIDTH  = 16,
    parameter logic [7:0]  CE_THRESH  = 8'd16,
    localparam int         ID_W       = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ*ECC_WIDTH-1:0]    req_syndrome,
    output logic                            chk_valid,
    output logic                            chk_enable,
    output logic [DATA_WIDTH-1:0]           chk_data,
    output logic [ECC_WIDTH-1:0]            chk_syndrome,
    input  logic                            chk_error_detected,
    input  logic                            chk_is_correctable,
    input  logic                            chk_is_uncorrectable,
    input  logic [DATA_WIDTH-1:0]           chk_data_corrected,
    output logic                            rsp_valid,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_ce,
    output logic                            rsp_ue,
    output logic [NUM_REQ-1:0]              blocked,
    input  logic [NUM_REQ-1:0]              ue_clear,
    output logic                            ue_irq,
    output logic [7:0]                      ce_count,
    output logic [7:0]                      ue_count,
    output logic                            ce_alert
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                 r_state, w_state_nxt;
    logic [ID_W-1:0]        r_rr_ptr, r_id, w_grant_id;
    logic                   w_grant_vld, w_hs, w_done, w_rsp_ce, w_rsp_ue, w_ce_inc, w_ue_inc;
    logic [NUM_REQ-1:0]     w_eligible, w_ue_set, r_blocked;
    logic [DATA_WIDTH-1:0]  r_data, r_rsp_data;
    logic [ECC_WIDTH-1:0]   r_syn;
    logic [ID_W-1:0]        r_rsp_id;
    logic                   r_rsp_valid, r_rsp_ce, r_rsp_ue;
    logic [7:0]             r_ce_count, r_ue_count;

    assign w_eligible = req_valid & ~r_blocked;

    // First eligible index at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_vld && w_eligible[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        chk_valid   = 1'b0;
        chk_enable  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    req_ready[w_grant_id] = 1'b1;
                    w_state_nxt           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                chk_valid   = 1'b1;
                chk_enable  = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Enable stays up so the classifier's statistics see error_detected.
                chk_enable  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_hs     = (r_state == S_IDLE) && w_grant_vld;
    assign w_done   = (r_state == S_WAIT);
    assign w_rsp_ce = chk_error_detected & chk_is_correctable;
    assign w_rsp_ue = chk_error_detected & chk_is_uncorrectable;
    assign w_ce_inc = w_done && w_rsp_ce && (r_ce_count != 8'hFF);
    assign w_ue_inc = w_done && w_rsp_ue && (r_ue_count != 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_data   <= '0;
            r_syn    <= '0;
        end else if (w_hs) begin
            r_id     <= w_grant_id;
            r_data   <= req_data[w_grant_id*DATA_WIDTH +: DATA_WIDTH];
            r_syn    <= req_syndrome[w_grant_id*ECC_WIDTH +: ECC_WIDTH];
            r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
        end
    end

    always_comb begin
        w_ue_set = '0;
        if (w_done && w_rsp_ue) w_ue_set[r_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_ce    <= 1'b0;
            r_rsp_ue    <= 1'b0;
            r_blocked   <= '0;
            r_ce_count  <= '0;
            r_ue_count  <= '0;
        end else begin
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_id   <= r_id;
                r_rsp_data <= chk_data_corrected;
                r_rsp_ce   <= w_rsp_ce;
                r_rsp_ue   <= w_rsp_ue;
            end
            // A quarantine set in the same cycle as its clear must win.
            r_blocked <= (r_blocked & ~ue_clear) | w_ue_set;
            if (w_ce_inc) r_ce_count <= r_ce_count + 8'd1;
            if (w_ue_inc) r_ue_count <= r_ue_count + 8'd1;
        end
    end

`ifdef ECC_ARB_CE_THRESH_EN
    logic r_ce_alert;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_ce_alert <= 1'b0;
        else if (w_ce_inc) r_ce_alert <= r_ce_alert | ((r_ce_count + 8'd1) >= CE_THRESH);
    end

    assign ce_alert = r_ce_alert;
`else
    logic [7:0] w_unused_thresh;
    assign w_unused_thresh = CE_THRESH;
    assign ce_alert        = 1'b0;
`endif

    assign chk_data     = r_data;
    assign chk_syndrome = r_syn;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_data     = r_rsp_data;
    assign rsp_ce       = r_rsp_ce;
    assign rsp_ue       = r_rsp_ue;
    assign blocked      = r_blocked;
    assign ue_irq       = |r_blocked;
    assign ce_count     = r_ce_count;
    assign ue_count     = r_ue_count;

endmodule

// File: tb/tb_ecc_chk_arbiter.sv
// Self-checking bench for ecc_chk_arbiter: vector table plus hand-written multi-cycle sequences.
// A behavioural classifier stand-in answers each chk_valid beat one cycle later.
module tb_ecc_chk_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 128;
    localparam int EW      = 16;
    localparam int ID_W    = 2;
`ifdef ECC_ARB_CE_THRESH_EN
    localparam bit ALERT_EN = 1'b1;
`else
    localparam bit ALERT_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid, req_ready, blocked, ue_clear;
    logic [NUM_REQ*DW-1:0]    req_data;
    logic [NUM_REQ*EW-1:0]    req_syndrome;
    logic                     chk_valid, chk_enable;
    logic [DW-1:0]            chk_data, chk_data_corrected, rsp_data;
    logic [EW-1:0]            chk_syndrome;
    logic                     chk_error_detected, chk_is_correctable, chk_is_uncorrectable;
    logic                     rsp_valid, rsp_ce, rsp_ue, ue_irq, ce_alert;
    logic [ID_W-1:0]          rsp_id;
    logic [7:0]               ce_count, ue_count;

    always #5 clk = ~clk;

    ecc_chk_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ECC_WIDTH(EW), .CE_THRESH(8'd16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_syndrome(req_syndrome),
        .chk_valid(chk_valid), .chk_enable(chk_enable), .chk_data(chk_data), .chk_syndrome(chk_syndrome),
        .chk_error_detected(chk_error_detected), .chk_is_correctable(chk_is_correctable),
        .chk_is_uncorrectable(chk_is_uncorrectable), .chk_data_corrected(chk_data_corrected),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ce(rsp_ce), .rsp_ue(rsp_ue),
        .blocked(blocked), .ue_clear(ue_clear), .ue_irq(ue_irq),
        .ce_count(ce_count), .ue_count(ue_count), .ce_alert(ce_alert)
    );

    // Classifier stand-in: zero syndrome = clean, one set bit = CE (flip data bit 0), otherwise UE (raw data).
    initial begin
        chk_error_detected   = 1'b0;
        chk_is_correctable   = 1'b0;
        chk_is_uncorrectable = 1'b0;
        chk_data_corrected   = '0;
    end

    always @(negedge clk) begin
        if (chk_valid) begin
            chk_error_detected   = (chk_syndrome != '0);
            chk_is_correctable   = ($countones(chk_syndrome) == 1);
            chk_is_uncorrectable = (chk_syndrome != '0) && ($countones(chk_syndrome) != 1);
            chk_data_corrected   = ($countones(chk_syndrome) == 1) ? (chk_data ^ DW'(1)) : chk_data;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_data(input int i);
        return {32'hDEAD_0000 + 32'(i), 32'hBEEF_1000 + 32'(i), 32'hC0DE_2000 + 32'(i), 32'hF00D_3000 + 32'(i)};
    endfunction

    // One full beat: grant, issue, wait, response. clr is driven on ue_clear during the WAIT cycle.
    task automatic run_beat(input logic [3:0] valid, input logic [15:0] syn, input int exp_id,
                            input bit exp_ce, input bit exp_ue, input logic [3:0] exp_blk,
                            input logic [7:0] exp_cec, input logic [7:0] exp_uec, input logic [3:0] clr);
        int n;
        logic [DW-1:0] exp_data;
        n            = 0;
        req_valid    = valid;
        req_syndrome = {NUM_REQ{syn}};
        #1;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("grant", DW'(req_ready), DW'(4'b0001 << exp_id));
        if (req_ready == '0) begin
            req_valid = '0;
            return;
        end
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        check("issue_ctl", DW'({chk_valid, chk_enable}), DW'(2'b11));
        check("issue_data", chk_data, lane_data(exp_id));
        check("issue_syn", DW'(chk_syndrome), DW'(syn));
        @(posedge clk); #1; ue_clear = clr;
        @(negedge clk);
        check("wait_ctl", DW'({chk_valid, chk_enable, rsp_valid}), DW'(3'b010));
        @(posedge clk); #1; ue_clear = '0;
        @(negedge clk);
        exp_data = exp_ce ? (lane_data(exp_id) ^ DW'(1)) : lane_data(exp_id);
        check("rsp_valid", DW'(rsp_valid), DW'(1'b1));
        check("rsp_id", DW'(rsp_id), DW'(exp_id));
        check("rsp_ce_ue", DW'({rsp_ce, rsp_ue}), DW'({exp_ce, exp_ue}));
        check("rsp_data", rsp_data, exp_data);
        check("blocked", DW'({ue_irq, blocked}), DW'({|exp_blk, exp_blk}));
        check("counts", DW'({ce_count, ue_count}), DW'({exp_cec, exp_uec}));
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] syn;
        int          id;
        bit          ce;
        bit          ue;
        logic [3:0]  blk;
        logic [7:0]  cec;
        logic [7:0]  uec;
    } vec_t;

    vec_t vecs[8];
    int   n, cyc, nh, nr, prev_cyc;
    bit   ok;

    initial begin
        vecs[0] = '{4'b0100, 16'h0004, 2, 1'b1, 1'b0, 4'b0000, 8'd1, 8'd0};
        vecs[1] = '{4'b0101, 16'h0000, 0, 1'b0, 1'b0, 4'b0000, 8'd1, 8'd0};
        vecs[2] = '{4'b0101, 16'h0000, 2, 1'b0, 1'b0, 4'b0000, 8'd1, 8'd0};
        vecs[3] = '{4'b0010, 16'h0003, 1, 1'b0, 1'b1, 4'b0010, 8'd1, 8'd1};
        vecs[4] = '{4'b0011, 16'h0001, 0, 1'b1, 1'b0, 4'b0010, 8'd2, 8'd1};
        vecs[5] = '{4'b1010, 16'h0000, 3, 1'b0, 1'b0, 4'b0010, 8'd2, 8'd1};
        vecs[6] = '{4'b1111, 16'h8000, 0, 1'b1, 1'b0, 4'b0010, 8'd3, 8'd1};
        vecs[7] = '{4'b1111, 16'h0000, 2, 1'b0, 1'b0, 4'b0010, 8'd3, 8'd1};

        rst_n        = 1'b0;
        req_valid    = '0;
        ue_clear     = '0;
        req_syndrome = '0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = lane_data(i);
        #2;
        check("reset_ctl", DW'({req_ready, chk_valid, chk_enable, rsp_valid, rsp_ce, rsp_ue, ue_irq, ce_alert}), '0);
        check("reset_state", DW'({blocked, ce_count, ue_count, rsp_id}), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++)
            run_beat(vecs[v].valid, vecs[v].syn, vecs[v].id, vecs[v].ce, vecs[v].ue,
                     vecs[v].blk, vecs[v].cec, vecs[v].uec, 4'b0000);

        // Quarantined requester 1 alone never gets a grant.
        req_valid = 4'b0010;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            if (req_ready != '0) ok = 1'b0;
        end
        check("blocked_skip", DW'(ok), DW'(1'b1));
        check("ue_irq_held", DW'(ue_irq), DW'(1'b1));

        // Clear pulse unblocks on the next cycle and requester 1 wins again.
        ue_clear = 4'b0010;
        @(posedge clk); #1; ue_clear = '0;
        check("clear_unblock", DW'({ue_irq, blocked}), '0);
        check("clear_regrant", DW'(req_ready), DW'(4'b0010));
        run_beat(4'b0010, 16'h0000, 1, 1'b0, 1'b0, 4'b0000, 8'd3, 8'd1, 4'b0000);

        // UE set and ue_clear on the same bit in the same cycle: set wins.
        run_beat(4'b0010, 16'h0003, 1, 1'b0, 1'b1, 4'b0010, 8'd3, 8'd2, 4'b0010);

        // Clearing a bit that is not blocked changes nothing.
        ue_clear = 4'b0100;
        @(posedge clk); #1; ue_clear = '0;
        check("clear_noop", DW'(blocked), DW'(4'b0010));

        // Reset while the beat sits in WAIT.
        req_valid    = 4'b0100;
        req_syndrome = {NUM_REQ{16'h0004}};
        n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("rst_grant", DW'(req_ready), DW'(4'b0100));
        @(posedge clk); #1; req_valid = '0;
        @(posedge clk); #1;
        check("rst_in_wait", DW'({chk_valid, chk_enable}), DW'(2'b01));
        rst_n = 1'b0;
        #1;
        check("rst_ctl", DW'({req_ready, chk_valid, chk_enable, rsp_valid, rsp_ce, rsp_ue, ue_irq, ce_alert}), '0);
        check("rst_state", DW'({blocked, ce_count, ue_count, rsp_id}), '0);
        check("rst_data", rsp_data | chk_data | DW'(chk_syndrome), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b0;
        end
        check("rst_no_rsp", DW'(ok), DW'(1'b1));

        // Round-robin with all requesters pending: 0,1,2,3,... three cycles apart.
        req_syndrome = '0;
        req_valid    = '1;
        cyc = 0; nh = 0; prev_cyc = 0;
        while (nh < 12 && cyc < 60) begin
            #1;
            if (req_ready != '0) begin
                check("rr_grant", DW'(req_ready), DW'(4'b0001 << (nh % 4)));
                if (nh > 0) check("rr_gap", DW'(cyc - prev_cyc), DW'(3));
                prev_cyc = cyc;
                nh++;
            end
            @(negedge clk); cyc++;
        end
        req_valid = '0;
        check("rr_count", DW'(nh), DW'(12));
        repeat (5) @(negedge clk);

        // CE saturation and threshold alert.
        req_syndrome = {NUM_REQ{16'h0001}};
        req_valid    = '1;
        nr = 0; cyc = 0;
        while (nr < 300 && cyc < 1200) begin
            @(negedge clk); cyc++;
            if (rsp_valid) begin
                nr++;
                if (nr inside {1, 15, 16, 17, 255, 256, 300}) begin
                    check("ce_sat", DW'(ce_count), DW'((nr > 255) ? 255 : nr));
                    check("ce_alert", DW'(ce_alert), DW'(ALERT_EN && nr >= 16));
                end
            end
        end
        req_valid = '0;
        check("sat_beats", DW'(nr), DW'(300));
        repeat (5) @(negedge clk);
        check("sat_final", DW'({ce_count, ue_count}), DW'({8'hFF, 8'h00}));
        check("alert_final", DW'(ce_alert), DW'(ALERT_EN));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
